// File: rtl/wor_stim_checker_if.sv
// Stimulus/response bundle between wor_stim_checker (master) and the wired-OR stage it exercises (slave).
// Signals are named from the checker's point of view: i_ into the checker, o_ out of it.
interface wor_stim_checker_if;
  logic       i_start;
  logic       i_out_in;
  logic       o_a;
  logic       o_b;
  logic       o_c;
  logic       o_busy;
  logic       o_done;
  logic [3:0] o_err_cnt;
  logic       o_pass;

  modport master (
    input  i_start, i_out_in,
    output o_a, o_b, o_c, o_busy, o_done, o_err_cnt, o_pass
  );

  modport slave (
    output i_start, i_out_in,
    input  o_a, o_b, o_c, o_busy, o_done, o_err_cnt, o_pass
  );
endinterface

// File: rtl/wor_stim_checker.sv
// Drives 3-bit vectors into a wired-OR stage, waits SETTLE_CYC cycles, and counts mismatches against (a&b)|(b|c).
// Optional feature: define WOR_STIM_RANDOM_EN to source vectors from an 8-bit LFSR instead of the vector index.
module wor_stim_checker #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned NUM_VEC    = 8
) (
  input  logic               clk,
  input  logic               rst,
  wor_stim_checker_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);
  localparam logic [7:0] LAST_IDX    = 8'(NUM_VEC - 1);
  localparam logic [3:0] ERR_MAX     = 4'hF;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_index;
  logic [3:0] r_settle;
  logic       r_a;
  logic       r_b;
  logic       r_c;
  logic [3:0] r_err_cnt;
  logic       r_pass;

  logic [2:0] w_vec;
  logic       w_expected;
  logic       w_mismatch;
  logic       w_last_vec;
  logic       w_start_run;
  logic       w_drive;
  logic       w_settling;
  logic       w_check;
  logic       w_finish;
  logic       w_busy;
  logic       w_done;

  assign w_expected = (r_a & r_b) | (r_b | r_c);
  assign w_mismatch = bus.i_out_in != w_expected;
  assign w_last_vec = r_index >= LAST_IDX;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_start_run = 1'b0;
    w_drive     = 1'b0;
    w_settling  = 1'b0;
    w_check     = 1'b0;
    w_finish    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_next      = DRIVE;
          w_start_run = 1'b1;
        end
      end
      DRIVE: begin
        w_busy  = 1'b1;
        w_drive = 1'b1;
        w_next  = SETTLE;
      end
      SETTLE: begin
        w_busy     = 1'b1;
        w_settling = 1'b1;
        if (r_settle <= 4'd1) begin
          w_next = CHECK;
        end
      end
      CHECK: begin
        w_busy  = 1'b1;
        w_check = 1'b1;
        w_next  = w_last_vec ? DONE : DRIVE;
      end
      DONE: begin
        w_done   = 1'b1;
        w_finish = 1'b1;
        w_next   = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

`ifdef WOR_STIM_RANDOM_EN
  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr_step;

  // Fibonacci LFSR, taps 8,6,5,4; the vector takes the freshly stepped value so each DRIVE sees a new state.
  assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_vec       = w_lfsr_step[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 8'hA5;
    end else if (w_start_run) begin
      r_lfsr <= 8'hA5;
    end else if (w_drive) begin
      r_lfsr <= w_lfsr_step;
    end
  end
`else
  assign w_vec = r_index[2:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_index <= 8'd0;
    end else if (w_start_run) begin
      r_index <= 8'd0;
    end else if (w_check && !w_last_vec) begin
      r_index <= r_index + 8'd1;
    end
  end

  // Loaded to SETTLE_CYC on DRIVE so SETTLE leaves when the count reaches one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle <= 4'd0;
    end else if (w_drive) begin
      r_settle <= SETTLE_LOAD;
    end else if (w_settling && (r_settle != 4'd0)) begin
      r_settle <= r_settle - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= 1'b0;
      r_b <= 1'b0;
      r_c <= 1'b0;
    end else if (w_drive) begin
      {r_a, r_b, r_c} <= w_vec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= 4'd0;
    end else if (w_start_run) begin
      r_err_cnt <= 4'd0;
    end else if (w_check && w_mismatch && (r_err_cnt != ERR_MAX)) begin
      r_err_cnt <= r_err_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pass <= 1'b0;
    end else if (w_start_run) begin
      r_pass <= 1'b0;
    end else if (w_finish) begin
      r_pass <= (r_err_cnt == 4'd0);
    end
  end

  assign bus.o_a       = r_a;
  assign bus.o_b       = r_b;
  assign bus.o_c       = r_c;
  assign bus.o_busy    = w_busy;
  assign bus.o_done    = w_done;
  assign bus.o_err_cnt = r_err_cnt;
  assign bus.o_pass    = r_pass;

endmodule

// File: tb/tb_wor_stim_checker.sv
// Bench for wor_stim_checker: table-driven runs, randomized downstream truth tables and hand-written corner sequences.
// The downstream stage is modelled as an 8-entry truth table indexed by {a,b,c}.
`timescale 1ns/1ps
module tb_wor_stim_checker;

  localparam int S_A = 2;
  localparam int N_A = 8;
  localparam int S_B = 1;
  localparam int N_B = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ttA;
  logic [7:0] ttB;
  int         checks   = 0;
  int         failures = 0;
  int         doneCountA = 0;

  always #5 clk = ~clk;

  wor_stim_checker_if ifA();
  wor_stim_checker_if ifB();

  assign ifA.i_out_in = ttA[{ifA.o_a, ifA.o_b, ifA.o_c}];
  assign ifB.i_out_in = ttB[{ifB.o_a, ifB.o_b, ifB.o_c}];

  wor_stim_checker #(.SETTLE_CYC(S_A), .NUM_VEC(N_A)) dutA (.clk(clk), .rst(rst), .bus(ifA.master));
  wor_stim_checker #(.SETTLE_CYC(S_B), .NUM_VEC(N_B)) dutB (.clk(clk), .rst(rst), .bus(ifB.master));

  always @(negedge clk) begin
    if (ifA.o_done === 1'b1) doneCountA <= doneCountA + 1;
  end

  typedef struct {
    logic [7:0] tt;
    int         expErr;
    logic       expPass;
    string      name;
  } vec_t;

  vec_t vecTable[4];

  // Vector k of a run, straight from the vector-source rule.
  function automatic logic [2:0] modelVec(input int k);
`ifdef WOR_STIM_RANDOM_EN
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i <= k; i++) l = {l[6:0], ^(l & 8'hB8)};
    return l[2:0];
`else
    return 3'(k % 8);
`endif
  endfunction

  function automatic int modelErr(input logic [7:0] tt, input int n);
    int         cnt;
    logic [2:0] v;
    logic       expv;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      v    = modelVec(k);
      expv = (v[2] & v[1]) | (v[1] | v[0]);
      if (tt[v] != expv) cnt++;
    end
    return (cnt > 15) ? 15 : cnt;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic setEntry(input int idx, input logic [7:0] tt, input int expErr, input string name);
    vecTable[idx].tt      = tt;
    vecTable[idx].expErr  = expErr;
    vecTable[idx].expPass = (expErr == 0);
    vecTable[idx].name    = name;
  endtask

  // Full run on dutA; optional extra start pulses mid-run (pokeAt >= 0) and during DONE.
  task automatic applyStimulus(input logic [7:0] tt, input int expErr, input logic expPass,
                               input int pokeAt, input bit pokeDone, input string name);
    int budget;
    int doneAt;
    int j;
    bit busyOk;
    bit orderOk;
    budget  = N_A * (S_A + 2) + 20;
    doneAt  = -1;
    busyOk  = 1'b1;
    orderOk = 1'b1;
    ttA     = tt;
    @(negedge clk);
    ifA.i_start = 1'b1;
    @(negedge clk);
    ifA.i_start = 1'b0;
    j = 0;
    while (j < budget) begin
      if (ifA.o_done === 1'b1) begin
        doneAt = j;
        break;
      end
      if (ifA.o_busy !== 1'b1) busyOk = 1'b0;
      if ((j % (S_A + 2) == 1) && (j / (S_A + 2) < N_A)) begin
        if ({ifA.o_a, ifA.o_b, ifA.o_c} !== modelVec(j / (S_A + 2))) orderOk = 1'b0;
      end
      ifA.i_start = (j == pokeAt);
      @(negedge clk);
      j++;
    end
    ifA.i_start = pokeDone;
    checkOutput({name, ".runLen"}, doneAt, N_A * (S_A + 2));
    checkOutput({name, ".busyDuringRun"}, busyOk, 1);
    checkOutput({name, ".vecOrder"}, orderOk, 1);
    @(negedge clk);
    ifA.i_start = 1'b0;
    checkOutput({name, ".doneOneCycle"}, ifA.o_done, 0);
    checkOutput({name, ".busyAfter"}, ifA.o_busy, 0);
    checkOutput({name, ".errCnt"}, ifA.o_err_cnt, expErr);
    checkOutput({name, ".pass"}, ifA.o_pass, expPass);
    repeat (2) @(negedge clk);
    checkOutput({name, ".holdVec"}, {ifA.o_a, ifA.o_b, ifA.o_c}, modelVec(N_A - 1));
    checkOutput({name, ".holdPass"}, ifA.o_pass, expPass);
    checkOutput({name, ".stayIdle"}, ifA.o_busy, 0);
  endtask

  // Long run on dutB, watching that err_cnt never decreases or wraps.
  task automatic runB(input logic [7:0] tt, input int expErr, input string name);
    int   budget;
    int   doneAt;
    int   j;
    bit   monoOk;
    logic [3:0] prevErr;
    budget = N_B * (S_B + 2) + 20;
    doneAt = -1;
    monoOk = 1'b1;
    ttB    = tt;
    @(negedge clk);
    ifB.i_start = 1'b1;
    @(negedge clk);
    ifB.i_start = 1'b0;
    prevErr = ifB.o_err_cnt;
    j = 0;
    while (j < budget) begin
      if (ifB.o_done === 1'b1) begin
        doneAt = j;
        break;
      end
      if (ifB.o_err_cnt < prevErr) monoOk = 1'b0;
      prevErr = ifB.o_err_cnt;
      @(negedge clk);
      j++;
    end
    checkOutput({name, ".runLen"}, doneAt, N_B * (S_B + 2));
    checkOutput({name, ".noWrap"}, monoOk, 1);
    @(negedge clk);
    checkOutput({name, ".errCnt"}, ifB.o_err_cnt, expErr);
    checkOutput({name, ".pass"}, ifB.o_pass, (expErr == 0));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] rtt;
    int         exp3;
    rst         = 1'b1;
    ifA.i_start = 1'b0;
    ifB.i_start = 1'b0;
    ttA         = 8'hEE;
    ttB         = 8'hEE;

    setEntry(0, 8'hEE, 0, "ideal");
    setEntry(2, 8'h11, N_A, "inverted");
`ifdef WOR_STIM_RANDOM_EN
    setEntry(1, 8'h00, modelErr(8'h00, N_A), "stuck0");
    setEntry(3, 8'hFF, modelErr(8'hFF, N_A), "stuck1");
`else
    setEntry(1, 8'h00, 6, "stuck0");
    setEntry(3, 8'hFF, 2, "stuck1");
`endif

    repeat (2) @(negedge clk);
    checkOutput("reset.abc", {ifA.o_a, ifA.o_b, ifA.o_c}, 0);
    checkOutput("reset.busy", ifA.o_busy, 0);
    checkOutput("reset.done", ifA.o_done, 0);
    checkOutput("reset.errCnt", ifA.o_err_cnt, 0);
    checkOutput("reset.pass", ifA.o_pass, 0);
    checkOutput("reset.busyB", ifB.o_busy, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      $display("[TB] table run %s", vecTable[i].name);
      applyStimulus(vecTable[i].tt, vecTable[i].expErr, vecTable[i].expPass, -1, 1'b0, vecTable[i].name);
    end

    $display("[TB] start pulses while busy and in DONE");
    applyStimulus(8'h00, modelErr(8'h00, N_A), 1'b0, 10, 1'b1, "ignoredStart");

    for (int r = 0; r < 6; r++) begin
      rtt = 8'($urandom);
      applyStimulus(rtt, modelErr(rtt, N_A), (modelErr(rtt, N_A) == 0), -1, 1'b0, "random");
    end

    // Abort during the SETTLE of vector 3 with some errors already counted.
    $display("[TB] mid-run reset");
    ttA = 8'h00;
    @(negedge clk);
    ifA.i_start = 1'b1;
    @(negedge clk);
    ifA.i_start = 1'b0;
    repeat (3 * (S_A + 2) + 1) @(negedge clk);
    exp3 = modelErr(8'h00, 3);
    checkOutput("midReset.vec3", {ifA.o_a, ifA.o_b, ifA.o_c}, modelVec(3));
    checkOutput("midReset.errBefore", ifA.o_err_cnt, exp3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midReset.abc", {ifA.o_a, ifA.o_b, ifA.o_c}, 0);
    checkOutput("midReset.busy", ifA.o_busy, 0);
    checkOutput("midReset.done", ifA.o_done, 0);
    checkOutput("midReset.errCnt", ifA.o_err_cnt, 0);
    checkOutput("midReset.pass", ifA.o_pass, 0);
    @(negedge clk);
    rst = 1'b0;
    doneCountA = 0;
    repeat (40) @(negedge clk);
    checkOutput("midReset.noDone", doneCountA, 0);
    checkOutput("midReset.stayIdle", ifA.o_busy, 0);
    applyStimulus(8'hEE, 0, 1'b1, -1, 1'b0, "afterReset");

    $display("[TB] saturation on long run");
    runB(8'h11, 15, "saturate");
    runB(8'hEE, 0, "longIdeal");
    rtt = 8'($urandom);
    runB(rtt, modelErr(rtt, N_B), "longRandom");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wor_stim_checker.md
WOR_STIM_CHECKER -- requirements
Module: wor_stim_checker

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 2, meaning idle cycles between driving a vector and sampling the result (legal 1..15).
REQ-002 The block SHALL have parameter NUM_VEC, default 8, meaning vectors per run (legal 1..255).
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port start  input  1  one-cycle run request, honoured only in IDLE.
REQ-006 The block SHALL have ports a, b, c  output  1 each  registered stimulus to the wired-OR stage downstream.
REQ-007 The block SHALL have port out_in  input  1  result returned from the downstream stage.
REQ-008 The block SHALL have port busy  output  1  high in every state except IDLE and DONE.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse at run end.
REQ-010 The block SHALL have port err_cnt  output  4  mismatch count of the current or last run.
REQ-011 The block SHALL have port pass  output  1  high when the last completed run had err_cnt == 0.

Function
REQ-012 The FSM SHALL have states IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-013 IDLE->DRIVE on start; the same edge SHALL clear err_cnt, clear pass, and load vector index 0.
REQ-014 In DRIVE, {a,b,c} SHALL be loaded from the vector source in one cycle, then the FSM SHALL go to SETTLE.
REQ-015 SETTLE SHALL last exactly SETTLE_CYC cycles, counted by a 4-bit down-counter, then go to CHECK.
REQ-016 In CHECK, the expected value SHALL be (a&b)|(b|c), computed from the registered a, b, c.
REQ-017 If out_in differs from the expected value in CHECK, err_cnt SHALL increment by one, saturating at 15.
REQ-018 After CHECK, the FSM SHALL go to DRIVE with the index incremented if index < NUM_VEC-1, else to DONE.
REQ-019 In DONE, done SHALL be high for one cycle and pass SHALL load (err_cnt == 0); the FSM SHALL then return to IDLE.
REQ-020 pass and err_cnt SHALL hold their values in IDLE until the next start.
REQ-021 Run length SHALL be NUM_VEC*(SETTLE_CYC+2) cycles from the DRIVE entry to DONE entry.
REQ-022 start while busy or in DONE SHALL be ignored.
REQ-023 a, b, c SHALL hold their last values through SETTLE, CHECK, DONE and IDLE.
REQ-024 The default vector source SHALL be index[2:0]; index SHALL be 8 bits and the vectors SHALL wrap every 8.

Reset
REQ-025 rst high SHALL immediately force state IDLE and set a=b=c=0, busy=0, done=0, err_cnt=0, pass=0, index=0, and the settle counter to 0.
REQ-026 rst asserted mid-run SHALL abort the run with no done pulse; a new start SHALL be required afterwards.

Configuration
REQ-027 With macro WOR_STIM_RANDOM_EN defined, the vector source SHALL be the low 3 bits of an 8-bit Fibonacci LFSR (taps 8,6,5,4).
REQ-028 With WOR_STIM_RANDOM_EN defined, the LFSR SHALL be seeded to 8'hA5 on reset and on start, and SHALL advance once per DRIVE.
REQ-029 Without WOR_STIM_RANDOM_EN, the LFSR SHALL be absent and the vector source SHALL be index[2:0].

Verification
REQ-030 Scenario ideal DUT: NUM_VEC=8, SETTLE_CYC=2, out_in=b|c, start pulse -> vectors 000..111 driven in order; done at cycle 32 after DRIVE entry; err_cnt=0; pass=1.
REQ-031 Scenario stuck-at-0 DUT: out_in=0 -> err_cnt=6 (vectors 010,011,101,110,111,001 mismatch; 000,100 match); pass=0.
REQ-032 Scenario saturation: NUM_VEC=40, out_in=~(b|c) -> err_cnt=15, never wraps; pass=0.
REQ-033 Scenario mid-run reset: rst pulsed during the SETTLE of vector 3 -> all outputs 0 asynchronously; no done; a following start runs a full clean run.
REQ-034 Scenario ignored start: start pulsed while busy -> run length and results unchanged.
REQ-035 Scenario WOR_STIM_RANDOM_EN defined: first vector = low 3 bits of the first LFSR step from 8'hA5, matching the bench reference model; ideal DUT -> pass=1.
